// File: rtl/nrf24_tx_scheduler_if.sv
// Handshake bundle between the payload source, the nRF24 controller and the
// TX scheduler: FIFO write side, controller request/status side, outcome reporting.
interface nrf24_tx_scheduler_if;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        ctl_ready;
    logic        tx_req;
    logic [7:0]  tx_data;
    logic [7:0]  status_data;
    logic        status_valid;
    logic        sent_pulse;
    logic        drop_pulse;
    logic [15:0] sent_cnt;
    logic [15:0] drop_cnt;
    logic        busy;

    modport master (
        output wr_en, wr_data, ctl_ready, status_data, status_valid,
        input  full, empty, overflow, tx_req, tx_data,
               sent_pulse, drop_pulse, sent_cnt, drop_cnt, busy
    );

    modport slave (
        input  wr_en, wr_data, ctl_ready, status_data, status_valid,
        output full, empty, overflow, tx_req, tx_data,
               sent_pulse, drop_pulse, sent_cnt, drop_cnt, busy
    );
endinterface

// File: rtl/nrf24_tx_scheduler.sv
// Queues payload bytes and feeds them one at a time to the nRF24 controller,
// retrying failed sends after a backoff gap and dropping after MAX_RETRY retries.
module nrf24_tx_scheduler #(
    parameter int FIFO_DEPTH     = 4,
    parameter int MAX_RETRY      = 3,
    parameter int BACKOFF_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               rstn,
    nrf24_tx_scheduler_if.slave bus
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int RW   = $clog2(MAX_RETRY + 2);
    localparam int TMAX = (TIMEOUT_CYCLES > BACKOFF_CYCLES) ? TIMEOUT_CYCLES : BACKOFF_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] BO_LAST  = TW'(BACKOFF_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EVAL, S_BACKOFF} state_t;
    state_t state, state_nxt;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop;

    logic [7:0]    tx_data_q, status_q;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry_cnt;
    logic [15:0]   sent_cnt_q, drop_cnt_q;
    logic          overflow_q, sent_q, drop_q;

    logic load, timer_clr, capture, timeout, do_sent, do_drop, retry_inc;
    logic st_ok, bo_done;
    logic status_unused;

    assign bus.full       = (count == CNT_FULL);
    assign bus.empty      = (count == '0);
    assign bus.overflow   = overflow_q;
    assign bus.tx_req     = (state == S_REQ);
    assign bus.tx_data    = tx_data_q;
    assign bus.sent_pulse = sent_q;
    assign bus.drop_pulse = drop_q;
    assign bus.sent_cnt   = sent_cnt_q;
    assign bus.drop_cnt   = drop_cnt_q;
    assign bus.busy       = (state != S_IDLE);

    assign push    = bus.wr_en && !bus.full;
    assign st_ok   = !status_q[4] && status_q[5];
    assign bo_done = (timer >= BO_LAST);
    assign status_unused = ^{status_q[7:6], status_q[3:0]};

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= bus.wr_data;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            overflow_q <= bus.wr_en && bus.full;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        timer_clr = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        pop       = 1'b0;
        do_sent   = 1'b0;
        do_drop   = 1'b0;
        retry_inc = 1'b0;
        case (state)
            S_IDLE:
                if (!bus.empty && bus.ctl_ready) begin
                    load      = 1'b1;
                    state_nxt = S_REQ;
                end
            S_REQ:
                // controller drops ready once it has taken the byte
                if (!bus.ctl_ready) begin
                    timer_clr = 1'b1;
                    state_nxt = S_WAIT;
                end
            S_WAIT:
                if (bus.status_valid) begin
                    capture   = 1'b1;
                    state_nxt = S_EVAL;
                end else if (timer == TO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = S_EVAL;
                end
            S_EVAL:
                if (st_ok) begin
                    pop       = 1'b1;
                    do_sent   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (retry_cnt < RETRY_MX) begin
                    retry_inc = 1'b1;
                    timer_clr = 1'b1;
                    state_nxt = S_BACKOFF;
                end else begin
                    pop       = 1'b1;
                    do_drop   = 1'b1;
                    state_nxt = S_IDLE;
                end
            S_BACKOFF:
                if (bo_done && bus.ctl_ready) state_nxt = S_REQ;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            tx_data_q  <= 8'h00;
            status_q   <= 8'h00;
            timer      <= '0;
            retry_cnt  <= '0;
            sent_cnt_q <= 16'h0000;
            drop_cnt_q <= 16'h0000;
            sent_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state  <= state_nxt;
            sent_q <= do_sent;
            drop_q <= do_drop;
            if (load) begin
                tx_data_q <= mem[rd_ptr];
                retry_cnt <= '0;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + RW'(1);
            end
            if (capture)      status_q <= bus.status_data;
            else if (timeout) status_q <= 8'h00;
            // one timer serves both the status wait and the backoff gap
            if (timer_clr)
                timer <= '0;
            else if (state == S_WAIT || (state == S_BACKOFF && !bo_done))
                timer <= timer + TW'(1);
            if (do_sent && sent_cnt_q != 16'hFFFF) sent_cnt_q <= sent_cnt_q + 16'd1;
            if (do_drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_nrf24_tx_scheduler.sv
// Scoreboard bench: every queued byte carries its expected fate; a monitor
// pops the entry on each sent/drop pulse and checks data, outcome and counters.
module tb_nrf24_tx_scheduler;
    localparam int DEPTH = 4;
    localparam int RETRY = 3;
    localparam int BO    = 20;
    localparam int TO    = 50;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    nrf24_tx_scheduler_if bus();

    nrf24_tx_scheduler #(
        .FIFO_DEPTH(DEPTH), .MAX_RETRY(RETRY),
        .BACKOFF_CYCLES(BO), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus)
    );

    typedef struct {
        logic [7:0] data;
        logic       sent;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0, n_err = 0;
    int   cyc = 0;
    int   exp_sent = 0, exp_drop = 0;
    logic req_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            if (bus.tx_req && !req_q) begin
                if (exp_q.size() > 0) chk("head_data", bus.tx_data, exp_q[0].data);
                else                  chk("req_unexpected", 1, 0);
            end
            if (bus.sent_pulse || bus.drop_pulse) begin
                if (exp_q.size() == 0) begin
                    chk("pulse_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.sent) exp_sent++;
                    else        exp_drop++;
                    chk("sb_data", bus.tx_data, e.data);
                    chk("sb_sent", bus.sent_pulse, e.sent);
                    chk("sb_drop", bus.drop_pulse, !e.sent);
                    chk("sb_sent_cnt", bus.sent_cnt, exp_sent);
                    chk("sb_drop_cnt", bus.drop_cnt, exp_drop);
                end
            end
        end
        req_q = rstn && bus.tx_req;
    end

    task automatic chk_reset_outputs();
        chk("rst_tx_req", bus.tx_req, 0);
        chk("rst_tx_data", bus.tx_data, 8'h00);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_sent_pulse", bus.sent_pulse, 0);
        chk("rst_drop_pulse", bus.drop_pulse, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_sent_cnt", bus.sent_cnt, 0);
        chk("rst_drop_cnt", bus.drop_cnt, 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.wr_en = 1'b0;
        bus.status_valid = 1'b0;
        exp_q.delete();
        exp_sent = 0;
        exp_drop = 0;
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        rstn = 1'b1;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic track, input logic sent);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
        if (track) exp_q.push_back('{d, sent});
    endtask

    task automatic wait_req(output int rise);
        for (int i = 0; i < 2000; i++) begin
            if (bus.tx_req) break;
            @(negedge clk);
        end
        if (!bus.tx_req) chk("req_wait_timeout", 0, 1);
        rise = cyc;
    endtask

    // one attempt: accept the request, answer with status (or let it time out)
    task automatic serve(input logic [7:0] st, input logic use_to, input logic xs,
                         input logic xd, output int rise, output int wstart);
        wait_req(rise);
        bus.ctl_ready = 1'b0;
        @(negedge clk);
        chk("req_fall", bus.tx_req, 0);
        chk("busy_wait", bus.busy, 1);
        wstart = cyc;
        if (use_to) begin
            repeat (TO) @(negedge clk);
        end else begin
            bus.status_data  = st;
            bus.status_valid = 1'b1;
            @(negedge clk);
            bus.status_valid = 1'b0;
        end
        chk("pulse_early", bus.sent_pulse | bus.drop_pulse, 0);
        @(negedge clk);
        chk("sent_pulse", bus.sent_pulse, xs);
        chk("drop_pulse", bus.drop_pulse, xd);
        bus.ctl_ready = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, w, r0, w0, r1, w1;
        int rises[4];
        bus.wr_en = 1'b0;
        bus.wr_data = 8'h00;
        bus.ctl_ready = 1'b0;
        bus.status_data = 8'h00;
        bus.status_valid = 1'b0;
        @(negedge clk);

        // basic send
        do_reset();
        bus.ctl_ready = 1'b1;
        push_byte(8'h5A, 1'b1, 1'b1);
        chk("t1_req_not_yet", bus.tx_req, 0);
        chk("t1_not_empty", bus.empty, 0);
        @(negedge clk);
        chk("t1_req", bus.tx_req, 1);
        chk("t1_data", bus.tx_data, 8'h5A);
        serve(8'h2E, 1'b0, 1'b1, 1'b0, r, w);
        chk("t1_sent_cnt", bus.sent_cnt, 1);
        chk("t1_empty", bus.empty, 1);
        chk("t1_idle", bus.busy, 0);

        // all attempts fail -> drop after MAX_RETRY retries
        do_reset();
        bus.ctl_ready = 1'b1;
        push_byte(8'hA5, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            serve(8'h1E, 1'b0, 1'b0, (k == 3), r, w);
            rises[k] = r;
        end
        for (int k = 1; k < 4; k++) chk("t2_bo_gap", (rises[k] - rises[k-1]) >= BO, 1);
        chk("t2_drop_cnt", bus.drop_cnt, 1);
        chk("t2_sent_cnt", bus.sent_cnt, 0);
        chk("t2_empty", bus.empty, 1);
        repeat (BO + 5) @(negedge clk);
        chk("t2_no_more_req", bus.tx_req, 0);
        chk("t2_idle", bus.busy, 0);

        // fill, overflow, drain
        do_reset();
        bus.ctl_ready = 1'b0;
        bus.wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.wr_data = 8'h10 + 8'(i);
            @(negedge clk);
            if (i < 4) exp_q.push_back('{8'h10 + 8'(i), 1'b1});
            chk("t3_full", bus.full, (i >= 3));
            chk("t3_overflow", bus.overflow, (i == 4));
        end
        bus.wr_en = 1'b0;
        @(negedge clk);
        chk("t3_overflow_end", bus.overflow, 0);
        bus.ctl_ready = 1'b1;
        for (int i = 0; i < 4; i++) serve(8'h20, 1'b0, 1'b1, 1'b0, r, w);
        @(negedge clk);
        chk("t3_empty", bus.empty, 1);
        chk("t3_sb_drained", exp_q.size(), 0);
        repeat (10) @(negedge clk);
        chk("t3_no_fifth", bus.tx_req, 0);
        chk("t3_sent_cnt", bus.sent_cnt, 4);

        // status timeout then successful retry
        do_reset();
        bus.ctl_ready = 1'b1;
        push_byte(8'hC3, 1'b1, 1'b1);
        serve(8'h00, 1'b1, 1'b0, 1'b0, r0, w0);
        serve(8'h20, 1'b0, 1'b1, 1'b0, r1, w1);
        chk("t4_retry_at", r1 - w0, TO + 1 + BO);
        chk("t4_sent_cnt", bus.sent_cnt, 1);
        chk("t4_drop_cnt", bus.drop_cnt, 0);

        // both bits set is a failure; stray status during backoff is ignored
        do_reset();
        bus.ctl_ready = 1'b1;
        push_byte(8'h77, 1'b1, 1'b1);
        serve(8'h30, 1'b0, 1'b0, 1'b0, r, w);
        @(negedge clk);
        bus.status_data  = 8'h20;
        bus.status_valid = 1'b1;
        @(negedge clk);
        bus.status_valid = 1'b0;
        @(negedge clk);
        chk("t5_stray_pulse", bus.sent_pulse | bus.drop_pulse, 0);
        chk("t5_in_backoff", bus.busy, 1);
        serve(8'h20, 1'b0, 1'b1, 1'b0, r, w);
        chk("t5_sent_cnt", bus.sent_cnt, 1);
        chk("t5_drop_cnt", bus.drop_cnt, 0);

        // reset in the middle of a status wait
        do_reset();
        bus.ctl_ready = 1'b1;
        push_byte(8'h99, 1'b1, 1'b1);
        wait_req(r);
        bus.ctl_ready = 1'b0;
        @(negedge clk);
        chk("t6_waiting", bus.busy, 1);
        rstn = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk_reset_outputs();
        rstn = 1'b1;
        bus.ctl_ready = 1'b1;
        bus.status_data  = 8'h20;
        bus.status_valid = 1'b1;
        @(negedge clk);
        bus.status_valid = 1'b0;
        repeat (30) @(negedge clk);
        chk("t6_sent_cnt", bus.sent_cnt, 0);
        chk("t6_drop_cnt", bus.drop_cnt, 0);
        chk("t6_empty", bus.empty, 1);
        chk("t6_idle", bus.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/nrf24_tx_scheduler.md
NRF24_TX_SCHEDULER -- requirements
Module: nrf24_tx_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2): number of queued payload bytes.
REQ-002 SHALL have parameter MAX_RETRY, default 3: retransmit attempts after the first failed send.
REQ-003 SHALL have parameter BACKOFF_CYCLES, default 5000: idle gap between a failure and its retry.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000: maximum wait for a status report.
REQ-005 SHALL have port clk  in  1  system clock; the single clock of the block.
REQ-006 SHALL have port rstn  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-007 SHALL have ports wr_en in 1 and wr_data in 8: push one payload byte.
REQ-008 SHALL have ports full out 1, empty out 1, overflow out 1: FIFO flags; overflow is a 1-cycle pulse.
REQ-009 SHALL have ports ctl_ready in 1 (from controller cap_done), tx_req out 1, tx_data out 8.
REQ-010 SHALL have ports status_data in 8 and status_valid in 1: controller STATUS report.
REQ-011 SHALL have ports sent_pulse out 1 and drop_pulse out 1: 1-cycle outcome pulses.
REQ-012 SHALL have ports sent_cnt out 16, drop_cnt out 16, busy out 1.

Function
REQ-013 FIFO: write accepted iff wr_en && !full (full as registered before the edge); wr_en && full drops the byte and pulses overflow the next cycle.
REQ-014 FIFO: pointers wrap modulo FIFO_DEPTH; the head byte is popped only on success or drop; a same-cycle push and pop are both performed.
REQ-015 FSM states: S_IDLE, S_REQ, S_WAIT, S_EVAL, S_BACKOFF.
REQ-016 S_IDLE: if !empty && ctl_ready, latch the head byte into tx_data, clear retry_cnt, and go to S_REQ.
REQ-017 S_REQ: tx_req = 1; hold it until ctl_ready is sampled 0, then deassert tx_req and go to S_WAIT with the timer cleared.
REQ-018 S_REQ has no timeout; tx_data SHALL be stable from S_REQ entry until the byte is popped or dropped.
REQ-019 S_WAIT: on status_valid, register status_data and go to S_EVAL.
REQ-020 S_WAIT: if the timer reaches TIMEOUT_CYCLES-1 first, treat the attempt as a failure and go to S_EVAL with status forced to 8'h00.
REQ-021 S_EVAL success: if status bit4 (MAX_RT) is 0 and bit5 (TX_DS) is 1, pop, pulse sent_pulse, increment sent_cnt, and go to S_IDLE.
REQ-022 S_EVAL failure (any other status, including both bits set): if retry_cnt < MAX_RETRY, increment retry_cnt and go to S_BACKOFF.
REQ-023 S_EVAL failure with retry_cnt == MAX_RETRY: pop, pulse drop_pulse, increment drop_cnt, and go to S_IDLE.
REQ-024 S_BACKOFF: count BACKOFF_CYCLES cycles, then wait for ctl_ready = 1 and go to S_REQ, resending the same tx_data.
REQ-025 sent_cnt and drop_cnt saturate at 16'hFFFF.
REQ-026 busy = 1 in every state except S_IDLE.
REQ-027 status_valid outside S_WAIT SHALL be ignored.
REQ-028 Latency: tx_req rises on the cycle after the S_IDLE condition is met; sent_pulse and drop_pulse come one cycle after status capture.

Reset
REQ-029 While rstn = 0 at a rising edge: state S_IDLE, FIFO emptied, counters, retry_cnt and timers cleared.
REQ-030 While rstn = 0: tx_req=0, tx_data=8'h00, overflow=0, sent_pulse=0, drop_pulse=0, busy=0, empty=1, full=0.
REQ-031 Reset asserted mid-transaction SHALL abandon the in-flight byte with no pulse and no count change.

Verification
REQ-032 Push 8'h5A with ctl_ready=1 -> tx_req=1 and tx_data=5A on the next cycle; drop ctl_ready -> tx_req=0; status 8'h2E -> sent_pulse, sent_cnt=1, empty=1.
REQ-033 Status 8'h1E on every attempt (MAX_RETRY=3) -> 4 tx_req assertions, each at least BACKOFF_CYCLES apart; then drop_pulse, drop_cnt=1, byte popped.
REQ-034 Push 5 bytes into an empty FIFO (depth 4) with ctl_ready=0 -> full=1 after 4 pushes; overflow pulses once; the 5th byte is never sent.
REQ-035 Withhold status_valid -> timeout after TIMEOUT_CYCLES, retry follows; return 8'h20 on the retry -> sent_cnt=1, drop_cnt=0.
REQ-036 Assert rstn=0 during S_WAIT -> all outputs at reset values next cycle; after release, no sent_pulse or drop_pulse occurs for the old byte.
REQ-037 Status 8'h30 (both bits set) -> treated as failure; retry_cnt increments.
